// File: rtl/adc_downsamp_mc.sv
// Multi-channel accumulate-and-dump decimator (sum or average of 2^rate beats) feeding a FWFT output FIFO.
// Optional rounding in average mode is enabled by defining ADC_DOWNSAMP_ROUND_EN.
module adc_downsamp_mc #(
    parameter  int DATA_WIDTH    = 14,
    parameter  int CHANNELS      = 2,
    parameter  int FIFO_DEPTH    = 512,
    parameter  int MAX_RATE_LOG2 = 4,
    localparam int OW            = DATA_WIDTH + MAX_RATE_LOG2,
    localparam int RW            = $clog2(MAX_RATE_LOG2 + 1),
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [RW-1:0]            rate_log2,
    input  logic                     avg_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNELS*OW-1:0]   out_data,
    output logic [CW-1:0]            fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = MAX_RATE_LOG2;

    logic [IW-1:0]          idx;
    logic [RW-1:0]          blk_rate;
    logic                   blk_avg;
    logic [OW-1:0]          acc [CHANNELS];
    logic [CHANNELS*OW-1:0] res_q;
    logic                   pending;
    logic [CHANNELS*OW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic [RW-1:0]          rate_clamp;
    logic [RW-1:0]          eff_rate;
    logic                   eff_avg;
    logic [IW:0]            n_m1;
    logic                   last;
    logic                   accept;
    logic                   drop;
    logic                   pop;
    logic [OW-1:0]          rnd;
    logic [OW-1:0]          nxt_acc [CHANNELS];
    logic [CHANNELS*OW-1:0] result;

    // Parameters in force for this beat: live inputs at index 0, latched copies otherwise.
    always_comb begin
        rate_clamp = (rate_log2 > RW'(MAX_RATE_LOG2)) ? RW'(MAX_RATE_LOG2) : rate_log2;
        eff_rate   = (idx == '0) ? rate_clamp : blk_rate;
        eff_avg    = (idx == '0) ? avg_mode : blk_avg;
        n_m1       = (IW+1)'((1 << eff_rate) - 1);
        last       = ({1'b0, idx} == n_m1);
`ifdef ADC_DOWNSAMP_ROUND_EN
        rnd        = (eff_rate == '0) ? '0 : (OW'(1) << (eff_rate - RW'(1)));
`else
        rnd        = '0;
`endif
        result     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            nxt_acc[c] = ((idx == '0) ? '0 : acc[c]) + OW'(in_data[c*DATA_WIDTH +: DATA_WIDTH]);
            result[c*OW +: OW] = eff_avg ? ((nxt_acc[c] + rnd) >> eff_rate) : nxt_acc[c];
        end
    end

    // Credits count the pending result so the unconditional drain never overruns the FIFO.
    assign in_ready   = ({1'b0, count} + (CW+1)'(pending)) < (CW+1)'(FIFO_DEPTH);
    assign accept     = in_valid & in_ready;
    assign drop       = in_valid & ~in_ready;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign out_data   = fifo_empty ? '0 : mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx      <= '0;
            blk_rate <= '0;
            blk_avg  <= 1'b0;
            res_q    <= '0;
            pending  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
        end else begin
            pending <= accept & last;
            if (accept) begin
                for (int c = 0; c < CHANNELS; c++) acc[c] <= nxt_acc[c];
                if (idx == '0) begin
                    blk_rate <= rate_clamp;
                    blk_avg  <= avg_mode;
                end
                if (last) begin
                    idx   <= '0;
                    res_q <= result;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (pending) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({pending, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (pending) mem[wr_ptr] <= res_q;
    end

endmodule

// File: tb/tb_adc_downsamp_mc.sv
// Bench for adc_downsamp_mc: directed scenarios plus random traffic checked against a block-level model.
module tb_adc_downsamp_mc;
    localparam int DW    = 14;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int MAXR  = 4;
    localparam int OW    = DW + MAXR;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CH*DW-1:0] in_data = '0;
    logic [2:0]       rate_log2 = '0;
    logic             avg_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CH*OW-1:0] out_data;
    logic [2:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow;
    logic             ovf_clr = 1'b0;

    adc_downsamp_mc #(.DATA_WIDTH(DW), .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .MAX_RATE_LOG2(MAXR)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rate_log2(rate_log2), .avg_mode(avg_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: each completed block becomes one result tagged with the edge that completed it.
    typedef struct {
        logic [CH*OW-1:0] data;
        int               stamp;
    } res_t;

    res_t   q[$];
    int     cyc = 0;
    int     blk_n = 0;
    int     blk_rate = 0;
    bit     blk_avg = 1'b0;
    longint sums[CH];
    bit     ovf_m = 1'b0;

    task automatic model_beat(input logic [CH*DW-1:0] d, input int r, input bit a);
        res_t   res;
        longint rnd;
        longint v;
        if (blk_n == 0) begin
            blk_rate = (r > MAXR) ? MAXR : r;
            blk_avg  = a;
            for (int c = 0; c < CH; c++) sums[c] = 0;
        end
        for (int c = 0; c < CH; c++) sums[c] += longint'(d[c*DW +: DW]);
        blk_n++;
        if (blk_n == (1 << blk_rate)) begin
            rnd = 0;
`ifdef ADC_DOWNSAMP_ROUND_EN
            if (blk_rate > 0) rnd = longint'(1) << (blk_rate - 1);
`endif
            res.data = '0;
            for (int c = 0; c < CH; c++) begin
                v = blk_avg ? ((sums[c] + rnd) >> blk_rate) : sums[c];
                res.data[c*OW +: OW] = v[OW-1:0];
            end
            res.stamp = cyc;
            q.push_back(res);
            blk_n = 0;
        end
    endtask

    task automatic step(input bit v, input logic [CH*DW-1:0] d, input int r, input bit a,
                        input bit ordy, input bit clr);
        int fifo_cnt;
        bit rdy_e;
        bit val_e;
        @(negedge clk_in);
        fifo_cnt = 0;
        foreach (q[i]) if (q[i].stamp < cyc) fifo_cnt++;
        val_e = (fifo_cnt > 0);
        rdy_e = (q.size() < DEPTH);
        check("in_ready", in_ready, rdy_e);
        check("out_valid", out_valid, val_e);
        check("fifo_count", fifo_count, fifo_cnt);
        check("fifo_empty", fifo_empty, fifo_cnt == 0);
        check("fifo_full", fifo_full, fifo_cnt == DEPTH);
        check("overflow", overflow, ovf_m);
        if (val_e) check("out_data", out_data, q[0].data);
        in_valid  = v;
        in_data   = d;
        rate_log2 = 3'(r);
        avg_mode  = a;
        out_ready = ordy;
        ovf_clr   = clr;
        cyc++;
        if (ordy && val_e) void'(q.pop_front());
        if (v && rdy_e) model_beat(d, r, a);
        if (v && !rdy_e) ovf_m = 1'b1;
        else if (clr)    ovf_m = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_overflow", overflow, 0);
        q.delete();
        blk_n = 0;
        ovf_m = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    logic [CH*OW-1:0] e;
    logic [CH*DW-1:0] d;

    initial begin
        do_reset();

        // Sum, rate 2
        for (int k = 1; k <= 4; k++) step(1'b1, {14'h3fff, 14'(k)}, 2, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("tp1_pending", out_valid, 0);
        idle(1, 1'b0);
        e = {18'd65532, 18'd10};
        check("tp1_valid", out_valid, 1);
        check("tp1_data", out_data, e);
        idle(3, 1'b1);

        // Average, rate 2: 1,1,1,2 then 1,1,2,2
        step(1'b1, 28'd1, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 28'd1, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 28'd1, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 28'd2, 2, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("tp2a_avg", out_data[OW-1:0], 1);
        idle(3, 1'b1);
        step(1'b1, 28'd1, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 28'd1, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 28'd2, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 28'd2, 2, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
`ifdef ADC_DOWNSAMP_ROUND_EN
        check("tp2b_avg", out_data[OW-1:0], 2);
`else
        check("tp2b_avg", out_data[OW-1:0], 1);
`endif
        idle(3, 1'b1);

        // Rate 0 pass-through stream
        for (int i = 0; i < 100; i++) begin
            step(1'b1, {14'(i + 7), 14'(i)}, 0, 1'b0, 1'b1, 1'b0);
            check("tp3_ready", in_ready, 1);
        end
        idle(3, 1'b1);

        // Rate change mid-block, then clamp of rate 7
        step(1'b1, 28'd1, 2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 28'd2, 2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 28'd3, 1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 28'd4, 1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 28'd5, 1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 28'd6, 1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, {14'd100, 14'(i)}, 7, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill the FIFO with no consumer
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 28'(i), 0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("tp5_full", fifo_full, 1);
        check("tp5_ready", in_ready, 0);
        check("tp5_ovf", overflow, 1);
        step(1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        check("tp5_ovf_clr", overflow, 0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        check("tp5_ready_back", in_ready, 1);
        idle(6, 1'b1);

        // Reset in the middle of a block
        for (int k = 0; k < 3; k++) step(1'b1, 28'd1000, 2, 1'b0, 1'b1, 1'b0);
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, {14'(k), 14'(10 * k)}, 2, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        e = {18'd10, 18'd100};
        check("tp6_data", out_data, e);
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            d = CH*DW'($urandom);
            step(($urandom % 4) != 0, d, int'($urandom % 8), 1'($urandom % 2),
                 ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        idle(10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
